// File: rtl/iob_ram_dp_be_ctrl_pkg.sv
// Shared constants for the dual-master RAM request controller.
// IOB_RAM_DP_BE_CTRL_OREG_EN selects the 2-cycle read latency variant.
package iob_ram_dp_be_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned STRB_W     = DEF_DATA_W / 8;

`ifdef IOB_RAM_DP_BE_CTRL_OREG_EN
    localparam int unsigned RD_LAT = 2;
`else
    localparam int unsigned RD_LAT = 1;
`endif

    // Priority FSM encoding
    localparam logic [0:0] PRIO_A = 1'b0;
    localparam logic [0:0] PRIO_B = 1'b1;

endpackage

// File: rtl/iob_ram_dp_be_ctrl_rsp.sv
// Per-port read response path: read-pending flag, optional output stage, rdata hold.
// IOB_RAM_DP_BE_CTRL_OREG_EN adds one register stage on rvalid/rdata.
module iob_ram_dp_be_ctrl_rsp #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rd_grant,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic pend_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= rd_grant;
        end
    end

`ifdef IOB_RAM_DP_BE_CTRL_OREG_EN
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= pend_q;
            if (pend_q) begin
                rdata_q <= ram_dout;
            end
        end
    end

    always_comb begin
        rvalid = rvalid_q;
        rdata  = rdata_q;
    end
`else
    logic [DATA_W-1:0] hold_q;

    // Keep the last delivered word visible while no response is pending
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hold_q <= '0;
        end else if (pend_q) begin
            hold_q <= ram_dout;
        end
    end

    always_comb begin
        rvalid = pend_q;
        rdata  = pend_q ? ram_dout : hold_q;
    end
`endif

endmodule

// File: rtl/iob_ram_dp_be_ctrl.sv
// Two-master front end for the dual-port byte-enable RAM with same-address hazard arbitration.
// IOB_RAM_DP_BE_CTRL_OREG_EN (in the response sub-module) gives 2-cycle read latency.
module iob_ram_dp_be_ctrl
    import iob_ram_dp_be_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  a_valid,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic [DATA_W/8-1:0]   a_wstrb,
    output logic                  a_ready,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_valid,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    input  logic [DATA_W/8-1:0]   b_wstrb,
    output logic                  b_ready,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_rvalid,
    output logic                  ram_enA,
    output logic [DATA_W/8-1:0]   ram_weA,
    output logic [ADDR_W-1:0]     ram_addrA,
    output logic [DATA_W-1:0]     ram_dinA,
    input  logic [DATA_W-1:0]     ram_doutA,
    output logic                  ram_enB,
    output logic [DATA_W/8-1:0]   ram_weB,
    output logic [ADDR_W-1:0]     ram_addrB,
    output logic [DATA_W-1:0]     ram_dinB,
    input  logic [DATA_W-1:0]     ram_doutB
);

    logic [0:0] prio_q;
    logic [0:0] prio_d;
    logic       conflict_c;
    logic       grant_a;
    logic       grant_b;
    logic       rd_grant_a;
    logic       rd_grant_b;

    // Two reads to one address never conflict; any write involvement does
    always_comb begin
        conflict_c = a_valid & b_valid & (a_addr == b_addr) & ((|a_wstrb) | (|b_wstrb));
        grant_a    = a_valid & (~conflict_c | (prio_q == PRIO_A));
        grant_b    = b_valid & (~conflict_c | (prio_q == PRIO_B));
        rd_grant_a = grant_a & ~(|a_wstrb);
        rd_grant_b = grant_b & ~(|b_wstrb);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            prio_q <= PRIO_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Priority passes to whichever master was stalled this cycle
    always_comb begin
        prio_d = prio_q;
        case (prio_q)
            PRIO_A:  if (conflict_c) prio_d = PRIO_B;
            PRIO_B:  if (conflict_c) prio_d = PRIO_A;
            default: prio_d = PRIO_A;
        endcase
    end

    always_comb begin
        a_ready   = grant_a;
        b_ready   = grant_b;
        ram_enA   = grant_a;
        ram_enB   = grant_b;
        ram_weA   = grant_a ? a_wstrb : '0;
        ram_weB   = grant_b ? b_wstrb : '0;
        ram_addrA = a_addr;
        ram_addrB = b_addr;
        ram_dinA  = a_wdata;
        ram_dinB  = b_wdata;
    end

    iob_ram_dp_be_ctrl_rsp #(.DATA_W(DATA_W)) u_rsp_a (
        .clk      (clk),
        .arst_n   (arst_n),
        .rd_grant (rd_grant_a),
        .ram_dout (ram_doutA),
        .rvalid   (a_rvalid),
        .rdata    (a_rdata)
    );

    iob_ram_dp_be_ctrl_rsp #(.DATA_W(DATA_W)) u_rsp_b (
        .clk      (clk),
        .arst_n   (arst_n),
        .rd_grant (rd_grant_b),
        .ram_dout (ram_doutB),
        .rvalid   (b_rvalid),
        .rdata    (b_rdata)
    );

endmodule

// File: tb/tb_iob_ram_dp_be_ctrl.sv
// Bench for iob_ram_dp_be_ctrl: behavioural RAM + transaction model, per-cycle compare, directed scenarios.
// Honours IOB_RAM_DP_BE_CTRL_OREG_EN for the expected read latency.
module tb_iob_ram_dp_be_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
`ifdef IOB_RAM_DP_BE_CTRL_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic [SW-1:0] a_wstrb = '0, b_wstrb = '0;
    logic          a_ready, b_ready, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_enA, ram_enB;
    logic [SW-1:0] ram_weA, ram_weB;
    logic [AW-1:0] ram_addrA, ram_addrB;
    logic [DW-1:0] ram_dinA, ram_dinB;
    logic [DW-1:0] ram_doutA = '0, ram_doutB = '0;

    int checks = 0;
    int failures = 0;

    iob_ram_dp_be_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .arst_n(arst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
        .a_ready(a_ready), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_valid(b_valid), .b_addr(b_addr), .b_wdata(b_wdata), .b_wstrb(b_wstrb),
        .b_ready(b_ready), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .ram_enA(ram_enA), .ram_weA(ram_weA), .ram_addrA(ram_addrA), .ram_dinA(ram_dinA),
        .ram_doutA(ram_doutA),
        .ram_enB(ram_enB), .ram_weB(ram_weB), .ram_addrB(ram_addrB), .ram_dinB(ram_dinB),
        .ram_doutB(ram_doutB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural dual-port read-first RAM driven by the DUT
    logic [DW-1:0] ram_mem [2**AW];
    always @(posedge clk) begin
        if (ram_enA) ram_doutA <= ram_mem[ram_addrA];
        if (ram_enB) ram_doutB <= ram_mem[ram_addrB];
        for (int i = 0; i < int'(SW); i++) begin
            if (ram_weA[i]) ram_mem[ram_addrA][8*i +: 8] <= ram_dinA[8*i +: 8];
            if (ram_weB[i]) ram_mem[ram_addrB][8*i +: 8] <= ram_dinB[8*i +: 8];
        end
    end

    // Transaction-level reference: memory contents, priority owner, in-flight read responses
    logic [DW-1:0] ref_mem [2**AW];
    int            m_prio = 0;
    logic          vld_a [2] = '{1'b0, 1'b0};
    logic          vld_b [2] = '{1'b0, 1'b0};
    logic [DW-1:0] dat_a [2] = '{'0, '0};
    logic [DW-1:0] dat_b [2] = '{'0, '0};
    logic [DW-1:0] hold_a = '0, hold_b = '0;

    function automatic logic is_conflict();
        return a_valid && b_valid && (a_addr == b_addr) && (a_wstrb != 0 || b_wstrb != 0);
    endfunction

    function automatic logic exp_ga();
        return a_valid && (!is_conflict() || m_prio == 0);
    endfunction

    function automatic logic exp_gb();
        return b_valid && (!is_conflict() || m_prio == 1);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [SW-1:0] st);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < int'(SW); i++) if (st[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
    end

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_prio = 0;
            vld_a = '{1'b0, 1'b0};
            vld_b = '{1'b0, 1'b0};
            hold_a = '0;
            hold_b = '0;
        end else begin
            logic ga, gb, conf;
            ga = exp_ga();
            gb = exp_gb();
            conf = is_conflict();
            if (vld_a[LAT-1]) hold_a = dat_a[LAT-1];
            if (vld_b[LAT-1]) hold_b = dat_b[LAT-1];
            vld_a[1] = vld_a[0]; dat_a[1] = dat_a[0];
            vld_b[1] = vld_b[0]; dat_b[1] = dat_b[0];
            vld_a[0] = ga && (a_wstrb == 0);
            dat_a[0] = ref_mem[a_addr];
            vld_b[0] = gb && (b_wstrb == 0);
            dat_b[0] = ref_mem[b_addr];
            if (ga) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_wstrb);
            if (gb) ref_mem[b_addr] = merge(ref_mem[b_addr], b_wdata, b_wstrb);
            // The master left waiting gets the next contested slot
            if (conf) m_prio = ga ? 1 : 0;
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        logic ga, gb;
        ga = exp_ga();
        gb = exp_gb();
        chk("a_ready", 32'(a_ready), 32'(ga));
        chk("b_ready", 32'(b_ready), 32'(gb));
        chk("ram_enA", 32'(ram_enA), 32'(ga));
        chk("ram_enB", 32'(ram_enB), 32'(gb));
        chk("ram_weA", 32'(ram_weA), ga ? 32'(a_wstrb) : 32'd0);
        chk("ram_weB", 32'(ram_weB), gb ? 32'(b_wstrb) : 32'd0);
        chk("ram_addrA", 32'(ram_addrA), 32'(a_addr));
        chk("ram_addrB", 32'(ram_addrB), 32'(b_addr));
        chk("ram_dinA", ram_dinA, a_wdata);
        chk("ram_dinB", ram_dinB, b_wdata);
        chk("a_rvalid", 32'(a_rvalid), 32'(vld_a[LAT-1]));
        chk("b_rvalid", 32'(b_rvalid), 32'(vld_b[LAT-1]));
        chk("a_rdata", a_rdata, vld_a[LAT-1] ? dat_a[LAT-1] : hold_a);
        chk("b_rdata", b_rdata, vld_b[LAT-1] ? dat_b[LAT-1] : hold_b);
        chk("prio", 32'(dut.prio_q), 32'(m_prio));
    end

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic [SW-1:0] as, input logic bv, input logic [AW-1:0] ba,
                         input logic [DW-1:0] bd, input logic [SW-1:0] bs);
        @(posedge clk);
        #1;
        a_valid = av; a_addr = aa; a_wdata = ad; a_wstrb = as;
        b_valid = bv; b_addr = ba; b_wdata = bd; b_wstrb = bs;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_lat();
        for (int i = 0; i < LAT; i++) begin
            idle();
            settle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] da, db;
        repeat (2) @(posedge clk);
        settle();
        chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_prio", 32'(dut.prio_q), 32'd0);
        @(posedge clk); #1 arst_n = 1'b1;

        // Full-word write then read-back on A
        drive(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 1'b0, '0, '0, '0);
        settle();
        chk("wr5_a_ready", 32'(a_ready), 32'd1);
        drive(1'b1, 10'd5, '0, 4'h0, 1'b0, '0, '0, '0);
        settle();
        chk("rd5_a_ready", 32'(a_ready), 32'd1);
        idle_lat();
        chk("rd5_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("rd5_a_rdata", a_rdata, 32'hDEADBEEF);

        // Byte-strobe merge
        drive(1'b1, 10'd7, 32'h11223344, 4'hF, 1'b0, '0, '0, '0);
        drive(1'b1, 10'd7, 32'hAABBCCDD, 4'h4, 1'b0, '0, '0, '0);
        drive(1'b1, 10'd7, '0, 4'h0, 1'b0, '0, '0, '0);
        idle_lat();
        chk("be_a_rdata", a_rdata, 32'h11BB3344);
        idle();
        settle();
        chk("be_hold_rvalid", 32'(a_rvalid), 32'd0);
        chk("be_hold_rdata", a_rdata, 32'h11BB3344);

        // Write/read hazard on addr 3 from PRIO_A
        drive(1'b1, 10'd3, 32'hCAFEF00D, 4'hF, 1'b1, 10'd3, '0, 4'h0);
        settle();
        chk("cf_a_ready", 32'(a_ready), 32'd1);
        chk("cf_b_ready", 32'(b_ready), 32'd0);
        drive(1'b0, '0, '0, '0, 1'b1, 10'd3, '0, 4'h0);
        settle();
        chk("cf_b_ready2", 32'(b_ready), 32'd1);
        chk("cf_prio_b", 32'(dut.prio_q), 32'd1);
        idle_lat();
        chk("cf_b_rvalid", 32'(b_rvalid), 32'd1);
        chk("cf_b_rdata", b_rdata, 32'hCAFEF00D);

        // Two reads of one address are not a hazard
        drive(1'b1, 10'd9, 32'h99999999, 4'hF, 1'b0, '0, '0, '0);
        drive(1'b1, 10'd9, '0, 4'h0, 1'b1, 10'd9, '0, 4'h0);
        settle();
        chk("rr_a_ready", 32'(a_ready), 32'd1);
        chk("rr_b_ready", 32'(b_ready), 32'd1);
        idle_lat();
        chk("rr_a_rdata", a_rdata, 32'h99999999);
        chk("rr_b_rdata", b_rdata, 32'h99999999);
        chk("rr_prio", 32'(dut.prio_q), 32'd1);

        // Sustained write contention on addr 2, starting from PRIO_A
        @(posedge clk); #1 arst_n = 1'b0;
        @(posedge clk); #1 arst_n = 1'b1;
        da = 16'd0;
        db = 16'd0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 10'd2, {16'hA000, da}, 4'hF, 1'b1, 10'd2, {16'hB000, db}, 4'hF);
            settle();
            chk("sus_a_ready", 32'(a_ready), 32'((k % 2) == 0));
            chk("sus_b_ready", 32'(b_ready), 32'((k % 2) == 1));
            if (a_ready) da++;
            if (b_ready) db++;
        end
        drive(1'b1, 10'd2, '0, 4'h0, 1'b0, '0, '0, '0);
        idle_lat();
        chk("sus_last", a_rdata, 32'hB0000002);

        // Concurrent write A / read B at different addresses, plus top-of-range address
        drive(1'b1, 10'd1023, 32'h0BADCAFE, 4'hF, 1'b1, 10'd5, '0, 4'h0);
        settle();
        chk("cc_a_ready", 32'(a_ready), 32'd1);
        chk("cc_b_ready", 32'(b_ready), 32'd1);
        drive(1'b0, '0, '0, '0, 1'b1, 10'd1023, '0, 4'h0);
        idle_lat();
        chk("wrap_b_rdata", b_rdata, 32'h0BADCAFE);

        // Reset lands the cycle after a read grant
        drive(1'b1, 10'd5, '0, 4'h0, 1'b0, '0, '0, '0);
        settle();
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        arst_n = 1'b0;
        settle();
        chk("mr_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("mr_a_rdata", a_rdata, 32'd0);
        chk("mr_prio", 32'(dut.prio_q), 32'd0);
        @(posedge clk); #1 arst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mr_no_rvalid", 32'(a_rvalid), 32'd0);
            @(posedge clk);
        end

        idle();
        settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
